drive_sequencer: RTL
====================

# drive_sequencer

Sequences the brushless motor datapath: generates the `drv_mag` and `brake_n` inputs that feed the `brushless` commutation block, which in turn drives `mtr_drv`. It soft-ramps drive magnitude toward a requested target, and handles braking. It also monitors the hall sensors for stall and invalid codes, latching a fault that forces the motor into brake. All magnitude updates are aligned to `PWM_synch` so duty never changes mid-period.

## Interface
- `RAMP_STEP`, 16: `drv_mag` change per `PWM_synch` pulse while ramping.
- `STALL_PERIODS`, 64: PWM periods without a hall transition, while driving, that constitute a stall.
- `BRAKE_MIN`, 8: minimum PWM periods spent in BRAKE.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  rider drive request; low ramps the motor down to 0.
- `target_mag`  in  12  requested drive magnitude, unsigned.
- `brake_req`  in  1  brake request, level.
- `clr_fault`  in  1  fault clear; honoured only while `enable`=0.
- `hallGrn`, `hallYlw`, `hallBlu`  in  1 each  raw, asynchronous hall inputs.
- `PWM_synch`  in  1  one-cycle pulse per PWM period, from `mtr_drv`.
- `drv_mag`  out  12  registered magnitude to `brushless`.
- `brake_n`  out  1  registered; 0 = brake.
- `at_target`  out  1  high in RUN.
- `fault`  out  1  high in FAULT.
- `fault_code`  out  2  01 = stall, 10 = invalid hall, 00 = none; holds its value until cleared.

## Operation
- **Hall inputs**
  - Hall inputs pass through two flop stages before use, giving `hall_s`.
  - A valid transition is defined as a `hall_s` change to a code other than 000 or 111.
- **Effective target:** `eff = enable ? target_mag : 0`.
- **States:** IDLE, RAMP, RUN, BRAKE, FAULT.
- **IDLE**
  - `drv_mag`=0, `brake_n`=1.
  - Goes to RAMP when `enable`=1, `eff`≠0 and `brake_req`=0.
- **RAMP**
  - On each `PWM_synch`:
    - if `drv_mag`<`eff`, `drv_mag` = min(`drv_mag`+`RAMP_STEP`, `eff`);
    - if `drv_mag`>`eff`, `drv_mag` = max(`drv_mag`−`RAMP_STEP`, `eff`).
  - Arithmetic uses 13 bits and has no wrap.
  - After the update, goes to RUN if `drv_mag`==`eff`≠0, or to IDLE if `drv_mag`==`eff`==0.
- **RUN**
  - `drv_mag` is held.
  - Goes to RAMP in the cycle `eff`≠`drv_mag` is seen.
- **BRAKE**
  - Entered from IDLE, RAMP or RUN when `brake_req`=1.
  - `drv_mag` is forced to 0 and `brake_n`=0, both taking effect at the entry edge.
  - A brake counter clears on entry and increments on each `PWM_synch`, saturating at `BRAKE_MIN`.
  - Goes to IDLE when counter==`BRAKE_MIN` and `brake_req`=0.
- **Stall monitor** (RAMP or RUN with `drv_mag`≠0)
  - A stall counter increments on each `PWM_synch` and clears on any valid hall transition.
  - The counter is held at 0 in all other states/conditions.
  - When it reaches `STALL_PERIODS`, go to FAULT with code 01.
- **Invalid-hall monitor** (RAMP or RUN)
  - `hall_s` is 000 or 111 at two consecutive `PWM_synch` pulses → FAULT with code 10.
  - A valid code at any sample resets this check.
- **FAULT**
  - `drv_mag`=0, `brake_n`=0, `fault`=1.
  - Goes to IDLE when `clr_fault`=1 and `enable`=0; `fault_code` clears to 00 on that exit.
- **Priority when events coincide:** FAULT entry > BRAKE entry > ramp/run transitions.
  - A stall on the same edge as `brake_req` goes to FAULT.
- **Reset**, asserted at any time including mid-ramp or mid-brake, gives:
  - state IDLE, `drv_mag`=0, `brake_n`=1;
  - `at_target`=0, `fault`=0, `fault_code`=00;
  - all counters 0, hall sync flops 000.

## Timing
- All outputs are registered.
- A `PWM_synch` sampled high at edge N produces the new `drv_mag` after edge N.
- Hall-to-monitor latency is 2 cycles (synchronizer).
- Entry into BRAKE or FAULT forces `drv_mag`=0 and `brake_n`=0 one cycle after the causing input is sampled, regardless of `PWM_synch`.
- Ramp duration from 0 to target T is ceil(T/`RAMP_STEP`) PWM periods.
- `enable` deasserted in RUN: RAMP at the next edge, then stepping down on `PWM_synch` pulses to IDLE.
- `target_mag` is sampled every cycle; changes mid-period affect only the next `PWM_synch` step.

## Test plan
- **Ramp-up:** `PWM_synch` every 8 clocks, `enable`=1, `target_mag`=0x800, halls rotating every period → `drv_mag` rises by 16 per pulse and reaches 0x800 after 128 pulses; `at_target`=1 thereafter.
- **Ramp-down:** `enable`→0 from RUN at 0x0F8 → `drv_mag` steps 0x0E8 … 0x008, 0x000, then IDLE; 16 pulses total.
- **Brake:** `brake_req` pulsed for 2 periods during RAMP → next cycle `drv_mag`=0 and `brake_n`=0; stays in BRAKE for exactly 8 `PWM_synch` pulses, then IDLE with `brake_n`=1.
- **Stall:** `drv_mag`≠0 with halls frozen at 101 → `fault`=1 and `fault_code`=01 on the 64th pulse. `clr_fault` while `enable`=1 is ignored; with `enable`=0 it gives IDLE and `fault_code`=00.
- **Invalid hall:** `hall`=111 across two pulses in RUN → FAULT with code 10. A single 000 pulse followed by 100 causes no fault.
- **Reset mid-ramp and simultaneous events:** `rst` at `drv_mag`=0x300 → all outputs at reset values next cycle. Stall count reaching 64 on the same edge `brake_req` rises → FAULT, not BRAKE.

Source files
------------

// File: rtl/drive_sequencer.sv
// drive_sequencer
//   Produces the drive magnitude and brake control for the brushless
//   commutation block. It soft-ramps drv_mag toward the requested target,
//   handles braking, and watches the hall sensors for stall or invalid codes.
//   A detected fault latches and forces the motor into brake. Magnitude steps
//   occur only on PWM_synch, so the duty cycle never changes mid-period.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enable      drive request; when low, the motor ramps down to 0
//   target_mag  requested magnitude (12 bit, unsigned)
//   brake_req   brake request (level)
//   clr_fault   fault clear, honoured only while enable = 0
//   hallGrn/hallYlw/hallBlu  raw asynchronous hall inputs
//   PWM_synch   one-cycle pulse per PWM period
//   drv_mag     registered magnitude to the commutator
//   brake_n     registered brake control, 0 = brake
//   at_target   high in RUN
//   fault       high in FAULT
//   fault_code  01 = stall, 10 = invalid hall, 00 = none
//
// state   | meaning
// --------+------------------------------------------------------
// S_IDLE  | no drive, drv_mag = 0, waiting for an enable or brake
// S_RAMP  | stepping drv_mag toward the effective target
// S_RUN   | drv_mag equals the target and is held
// S_BRAKE | brake_n = 0 for at least BRAKE_MIN PWM periods
// S_FAULT | latched stall or invalid-hall fault, motor braked

module drive_sequencer #(
   parameter int RAMP_STEP     = 16,
   parameter int STALL_PERIODS = 64,
   parameter int BRAKE_MIN     = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [11:0] target_mag,
   input  logic        brake_req,
   input  logic        clr_fault,
   input  logic        hallGrn,
   input  logic        hallYlw,
   input  logic        hallBlu,
   input  logic        PWM_synch,
   output logic [11:0] drv_mag,
   output logic        brake_n,
   output logic        at_target,
   output logic        fault,
   output logic [1:0]  fault_code
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RAMP  = 3'd1,
      S_RUN   = 3'd2,
      S_BRAKE = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam int SW = $clog2(STALL_PERIODS + 1);
   localparam int BW = $clog2(BRAKE_MIN + 1);
   localparam logic [12:0]   STEP       = 13'(RAMP_STEP);
   localparam logic [SW-1:0] STALL_LAST = SW'(STALL_PERIODS - 1);
   localparam logic [BW-1:0] BRAKE_TOP  = BW'(BRAKE_MIN);

   state_t        state, state_nxt;
   logic [11:0]   mag_nxt;
   logic          brake_n_nxt;
   logic [1:0]    code_nxt;
   logic [SW-1:0] stall_cnt, stall_nxt;
   logic [BW-1:0] brake_cnt, brake_cnt_nxt;
   logic          inv_prev, inv_nxt;

   logic [2:0]    hall_meta, hall_s, hall_prev;
   logic          hall_bad, hall_valid_tr;
   logic          monitoring, stall_hit, inv_hit;

   logic [11:0]   eff;
   logic [12:0]   mag13, eff13, up13, dn13;
   logic [11:0]   step_val;

   assign eff           = enable ? target_mag : 12'd0;
   assign hall_bad      = (hall_s == 3'b000) || (hall_s == 3'b111);
   assign hall_valid_tr = (hall_s != hall_prev) && !hall_bad;
   assign monitoring    = (state == S_RAMP) || (state == S_RUN);

   // Stall is declared on the pulse that would bring the count to STALL_PERIODS,
   // so the fault lands on that same edge rather than one pulse later.
   assign stall_hit = monitoring && (drv_mag != 12'd0) && !hall_valid_tr &&
                      PWM_synch && (stall_cnt == STALL_LAST);
   assign inv_hit   = monitoring && PWM_synch && hall_bad && inv_prev;

   // One ramp step toward eff, computed in 13 bits and clamped at eff.
   always_comb begin
      mag13    = {1'b0, drv_mag};
      eff13    = {1'b0, eff};
      up13     = mag13 + STEP;
      dn13     = mag13 - STEP;
      step_val = drv_mag;
      if (mag13 < eff13) begin
         step_val = (up13 >= eff13) ? eff : up13[11:0];
      end else if (mag13 > eff13) begin
         step_val = (mag13 <= eff13 + STEP) ? eff : dn13[11:0];
      end
   end

   always_comb begin
      state_nxt     = state;
      mag_nxt       = drv_mag;
      brake_n_nxt   = 1'b1;
      code_nxt      = fault_code;
      stall_nxt     = stall_cnt;
      brake_cnt_nxt = brake_cnt;
      inv_nxt       = inv_prev;

      case (state)
         S_IDLE: begin
            mag_nxt = 12'd0;
            if (enable && (eff != 12'd0)) state_nxt = S_RAMP;
         end
         S_RAMP: begin
            if (PWM_synch) begin
               mag_nxt = step_val;
               if (step_val == eff) state_nxt = (eff == 12'd0) ? S_IDLE : S_RUN;
            end
         end
         S_RUN: begin
            if (eff != drv_mag) state_nxt = S_RAMP;
         end
         S_BRAKE: begin
            mag_nxt     = 12'd0;
            brake_n_nxt = 1'b0;
            if (PWM_synch && (brake_cnt != BRAKE_TOP)) brake_cnt_nxt = brake_cnt + 1'b1;
            if ((brake_cnt == BRAKE_TOP) && !brake_req) begin
               state_nxt   = S_IDLE;
               brake_n_nxt = 1'b1;
            end
         end
         S_FAULT: begin
            mag_nxt     = 12'd0;
            brake_n_nxt = 1'b0;
            if (clr_fault && !enable) begin
               state_nxt   = S_IDLE;
               brake_n_nxt = 1'b1;
               code_nxt    = 2'b00;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      if (monitoring && (drv_mag != 12'd0)) begin
         if (hall_valid_tr)  stall_nxt = '0;
         else if (PWM_synch) stall_nxt = stall_cnt + 1'b1;
      end
      if (monitoring && PWM_synch) inv_nxt = hall_bad;

      // Brake overrides ramp/run moves; fault overrides brake.
      if (brake_req && ((state == S_IDLE) || monitoring)) begin
         state_nxt     = S_BRAKE;
         mag_nxt       = 12'd0;
         brake_n_nxt   = 1'b0;
         brake_cnt_nxt = '0;
      end
      if (stall_hit || inv_hit) begin
         state_nxt   = S_FAULT;
         mag_nxt     = 12'd0;
         brake_n_nxt = 1'b0;
         code_nxt    = stall_hit ? 2'b01 : 2'b10;
      end

      // Monitors only run while driving; everywhere else they sit at zero.
      if ((state_nxt != S_RAMP) && (state_nxt != S_RUN)) begin
         stall_nxt = '0;
         inv_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         drv_mag    <= 12'd0;
         brake_n    <= 1'b1;
         at_target  <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
         stall_cnt  <= '0;
         brake_cnt  <= '0;
         inv_prev   <= 1'b0;
         hall_meta  <= 3'b000;
         hall_s     <= 3'b000;
         hall_prev  <= 3'b000;
      end else begin
         state      <= state_nxt;
         drv_mag    <= mag_nxt;
         brake_n    <= brake_n_nxt;
         at_target  <= (state_nxt == S_RUN);
         fault      <= (state_nxt == S_FAULT);
         fault_code <= code_nxt;
         stall_cnt  <= stall_nxt;
         brake_cnt  <= brake_cnt_nxt;
         inv_prev   <= inv_nxt;
         hall_meta  <= {hallGrn, hallYlw, hallBlu};
         hall_s     <= hall_meta;
         hall_prev  <= hall_s;
      end
   end

endmodule
